// File: rtl/memory_multi_bank_dual_port.sv
// Banked simple-dual-port RAM: num_banks independent banks, each with one write
// port and one registered, read-first read port, all sharing one clock.
module memory_multi_bank_dual_port #(
    parameter int num_bank_entries = 8,
    parameter int data_bit_width   = 32,
    parameter int num_banks        = 4,
    parameter int addr_bit_width   = $clog2(num_bank_entries)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [num_banks-1:0]      wr_en,
    input  logic [addr_bit_width-1:0] wr_addr [num_banks],
    input  logic [data_bit_width-1:0] wr_data [num_banks],
    input  logic [num_banks-1:0]      rd_en,
    input  logic [addr_bit_width-1:0] rd_addr [num_banks],
    output logic [data_bit_width-1:0] rd_data [num_banks]
);

    // One extra bit so the bound is representable when the depth is a power of two.
    localparam logic [addr_bit_width:0] entries = (addr_bit_width + 1)'(num_bank_entries);

    genvar gi;
    generate
        for (gi = 0; gi < num_banks; gi++) begin : g_bank
            logic [data_bit_width-1:0] mem [num_bank_entries];
            logic [data_bit_width-1:0] rd_data_reg;
            logic                      wr_in_range;
            logic                      rd_in_range;

            assign wr_in_range = ({1'b0, wr_addr[gi]} < entries);
            assign rd_in_range = ({1'b0, rd_addr[gi]} < entries);

            // Storage carries no reset so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (!rst && wr_en[gi] && wr_in_range) begin
                    mem[wr_addr[gi]] <= wr_data[gi];
                end
            end

            // Separate process from the write, so a same-address read sees the old word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg <= '0;
                end else if (rd_en[gi]) begin
                    rd_data_reg <= rd_in_range ? mem[rd_addr[gi]] : '0;
                end
            end

            assign rd_data[gi] = rd_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_memory_multi_bank_dual_port.sv
// Self-checking bench for memory_multi_bank_dual_port (default parameters):
// expected read words are queued as stimulus is driven and popped after each edge.
module tb_memory_multi_bank_dual_port;

    localparam int NB = 4;
    localparam int NE = 8;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [NB-1:0] wr_en;
    logic [AW-1:0] wr_addr [NB];
    logic [DW-1:0] wr_data [NB];
    logic [NB-1:0] rd_en;
    logic [AW-1:0] rd_addr [NB];
    logic [DW-1:0] rd_data [NB];

    logic [NB*DW-1:0] exp_q [$];
    logic [NB*DW-1:0] exp_v;
    logic [NB*DW-1:0] obs_v;
    logic [DW-1:0]    shadow [NB][NE];
    int               pass_cnt;
    int               total_cnt;

    memory_multi_bank_dual_port dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NB*DW-1:0] packed_rd();
        return {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        for (int b = 0; b < NB; b++) begin
            wr_addr[b] = wa;
            wr_data[b] = wd;
            rd_addr[b] = ra;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        wr_en = '0;
        rd_en = '1;
        set_all('0, '0, '0);
        exp_q.push_back('0);
        tick();
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL reset_initial: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("reset_initial rd_data=%h", obs_v);
        rst = 1'b0;
    endtask

    task automatic test_fill_readback();
        rd_en = '0;
        for (int i = 0; i < NE; i++) begin
            wr_en = '1;
            set_all(AW'(i), DW'(i), '0);
            for (int b = 0; b < NB; b++) shadow[b][i] = DW'(i);
            tick();
        end
        wr_en = '0;
        rd_en = '1;
        for (int i = 0; i < NE; i++) begin
            set_all('0, '0, AW'(i));
            exp_q.push_back({4{DW'(i)}});
            tick();
            exp_v = exp_q.pop_front();
            obs_v = packed_rd();
            total_cnt++;
            if (obs_v !== exp_v) $display("FAIL fill_readback addr %0d: got %h expected %h", i, obs_v, exp_v);
            else pass_cnt++;
            $display("fill_readback addr=%0d rd_data=%h", i, obs_v);
        end
    endtask

    task automatic test_reset_midrun();
        // rd_data currently holds 7 in every bank; a write during reset must be dropped.
        rd_en = '1;
        wr_en = '1;
        set_all(3'd5, 32'hDEAD_BEEF, 3'd1);
        #2;
        rst = 1'b1;
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL reset_async: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("reset_async rd_data=%h", obs_v);
        exp_q.push_back('0);
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL reset_hold: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("reset_hold rd_data=%h", obs_v);
        rst   = 1'b0;
        wr_en = '0;
        set_all('0, '0, 3'd5);
        exp_q.push_back({4{shadow[0][5]}});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL reset_write_suppressed: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("reset_write_suppressed rd_data=%h", obs_v);
    endtask

    task automatic test_same_address();
        wr_en = '1;
        rd_en = '1;
        set_all('0, '0, '0);
        exp_q.push_back('0);
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL same_addr setup: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        for (int i = 1; i < 32; i++) begin
            set_all('0, DW'(i), '0);
            exp_q.push_back({4{DW'(i - 1)}});
            tick();
            exp_v = exp_q.pop_front();
            obs_v = packed_rd();
            total_cnt++;
            if (obs_v !== exp_v) $display("FAIL same_addr i=%0d: got %h expected %h", i, obs_v, exp_v);
            else pass_cnt++;
            $display("same_addr i=%0d rd_data=%h", i, obs_v);
        end
        for (int b = 0; b < NB; b++) shadow[b][0] = 32'd31;
        wr_en = '0;
    endtask

    task automatic test_independence();
        rd_en = '0;
        wr_en = '1;
        set_all(3'd3, '0, '0);
        tick();
        wr_en = 4'b0101;
        set_all(3'd3, 32'hA5A5_A5A5, '0);
        tick();
        for (int b = 0; b < NB; b++) shadow[b][3] = (b % 2 == 0) ? 32'hA5A5_A5A5 : 32'h0;
        wr_en = '0;
        rd_en = '1;
        set_all('0, '0, 3'd3);
        exp_q.push_back({32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL bank_mask: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("bank_mask rd_data=%h", obs_v);
        for (int b = 0; b < NB; b++) rd_addr[b] = AW'(b + 1);
        exp_q.push_back({32'd4, 32'hA5A5_A5A5, 32'd2, 32'd1});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL per_bank_addr: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("per_bank_addr rd_data=%h", obs_v);
    endtask

    task automatic test_read_hold();
        // Banks 0 and 2 are held at 1 and A5A5A5A5; banks 1 and 3 read address 6 read-first.
        rd_en = 4'b1010;
        wr_en = '1;
        for (int b = 0; b < NB; b++) begin
            rd_addr[b] = 3'd6;
            wr_addr[b] = 3'd6;
            wr_data[b] = 32'h1111_0000 + DW'(b);
            shadow[b][6] = 32'h1111_0000 + DW'(b);
        end
        exp_q.push_back({32'd6, 32'hA5A5_A5A5, 32'd6, 32'd1});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL read_hold: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("read_hold rd_data=%h", obs_v);
        rd_en = '1;
        wr_en = '0;
        exp_q.push_back({32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = packed_rd();
        total_cnt++;
        if (obs_v !== exp_v) $display("FAIL read_reenable: got %h expected %h", obs_v, exp_v);
        else pass_cnt++;
        $display("read_reenable rd_data=%h", obs_v);
    endtask

    task automatic test_write_gating();
        rd_en = '0;
        wr_en = '0;
        for (int i = 0; i < NE; i++) begin
            for (int b = 0; b < NB; b++) begin
                wr_addr[b] = AW'(i);
                wr_data[b] = $urandom;
            end
            tick();
        end
        rd_en = '1;
        for (int i = 0; i < NE; i++) begin
            for (int b = 0; b < NB; b++) rd_addr[b] = AW'(i);
            exp_q.push_back({shadow[3][i], shadow[2][i], shadow[1][i], shadow[0][i]});
            tick();
            exp_v = exp_q.pop_front();
            obs_v = packed_rd();
            total_cnt++;
            if (obs_v !== exp_v) $display("FAIL wr_gating addr %0d: got %h expected %h", i, obs_v, exp_v);
            else pass_cnt++;
            $display("wr_gating addr=%0d rd_data=%h", i, obs_v);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_fill_readback();
        test_reset_midrun();
        test_same_address();
        test_independence();
        test_read_hold();
        test_write_gating();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/memory_multi_bank_dual_port.md
# memory_multi_bank_dual_port

Banked simple-dual-port RAM: `num_banks` independent banks, each with its own write port and registered read port, all on one clock. It serves as parallel scratch storage for datapaths that move one word per bank per cycle. Every bank supports a write and a read in the same cycle, to any address, including the same address.

## Interface

Parameters:
- `num_bank_entries`, default 8: words per bank.
- `data_bit_width`, default 32: word width in bits.
- `num_banks`, default 4: number of independent banks.
- `addr_bit_width`, default `$clog2(num_bank_entries)`: per-bank address width. This is derived and must not be overridden.

Ports (clock and reset first). Per-bank buses are unpacked arrays indexed 0..`num_banks`-1.
- `clk`  in  1  single clock for all banks and both ports.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  `num_banks`  per-bank write enable. Bit b controls bank b.
- `wr_addr[num_banks]`  in  `addr_bit_width` each  write address per bank.
- `wr_data[num_banks]`  in  `data_bit_width` each  write data per bank.
- `rd_en`  in  `num_banks`  per-bank read enable.
- `rd_addr[num_banks]`  in  `addr_bit_width` each  read address per bank.
- `rd_data[num_banks]`  out  `data_bit_width` each  registered read data per bank.

## Operation

- **Storage.** Each bank is an array of `num_bank_entries` words of `data_bit_width` bits. Banks share no storage and have no cross-bank interaction.
- **Write.** On a `clk` rising edge with `wr_en[b]`=1, `mem[b][wr_addr[b]]` <= `wr_data[b]`. With `wr_en[b]`=0, bank b is unchanged.
- **Read.** On a `clk` rising edge with `rd_en[b]`=1, `rd_data[b]` <= `mem[b][rd_addr[b]]`. With `rd_en[b]`=0, `rd_data[b]` holds its previous value.
- **Same-address collision (read-first).** If a read and a write hit the same address of the same bank on the same edge, `rd_data[b]` gets the old contents. The new data becomes readable on the next enabled read.
- **Out-of-range addresses.** This applies only when `num_bank_entries` is not a power of two.
  - A write to an address >= `num_bank_entries` is ignored.
  - A read from such an address loads 0 into `rd_data[b]`.
- **Reset.**
  - `rst`=1 asynchronously clears every `rd_data[b]` to 0.
  - Memory contents are not reset; they are X after power-up until written.
  - While `rst` is asserted, writes and reads are suppressed.
- **Independence.** Banks are fully independent. Any mix of enables and addresses across banks is legal in the same cycle.

## Timing

- Write latency: data written at edge N is visible to a read sampled at edge N+1 or later.
- Read latency: 1 cycle. With `rd_addr`/`rd_en` set up before edge N, `rd_data` is valid after edge N and stable until the next enabled read edge.
- Back-to-back operation: one read and one write per bank per cycle, sustained, with no stalls and no handshake.
- `rd_data` is a pure register output. There is no combinational path from any input to `rd_data`.
- Reset deassertion is synchronous to `clk` by system convention. The first active edge after deassertion performs normal operations.

## Test plan

- **Reset.** Assert `rst` mid-run with `rd_data` nonzero -> all `rd_data[b]`=0 immediately, without waiting for a clock edge. Hold `rd_en`=1 during reset -> `rd_data` stays 0.
- **Fill then read back (defaults).**
  - Write cycle i (i=0..7) writes value i to address i in all 4 banks (`wr_en`=4'hF).
  - Then, with `rd_en`=4'hF, stepping `rd_addr` 0..7 one per cycle -> `rd_data[b]`=i one cycle after address i is presented, for every bank.
- **Same-address read/write (read-first).**
  - Setup: `wr_addr`=`rd_addr`=0 in all banks, both enables on, `wr_data`=0 for one cycle.
  - Then present `wr_data`=i for i=1..31, one per cycle.
  - Expected: after each edge, `rd_data[b]`=i-1.
- **Per-bank independence.**
  - Stimulus: `wr_en`=4'b0101, writing 32'hA5A5A5A5 to address 3, over a prior background of 0.
  - Expected: reading address 3 returns A5A5A5A5 in banks 0 and 2, and 0 in banks 1 and 3.
  - Different `rd_addr` per bank in the same cycle -> each bank returns its own word.
- **Read hold.** Drop `rd_en`[b] to 0 while changing `rd_addr` and writing new data -> `rd_data[b]` remains at its last value. Re-enable -> it updates on the next edge.
- **Write-enable gating.** `wr_en`=0 with changing `wr_addr`/`wr_data` for 8 cycles -> a subsequent readback of all addresses shows the contents unchanged.
